// File: rtl/uart_rx_fsm.sv
// UART receive controller. It drives the companion bit timer through
// reset_timer, checks the start bit at its half-bit point, and deserialises
// an LSB-first frame: start, data bits, optional parity, one stop bit.
// Each finished frame produces a one-cycle rx_valid pulse. The received word
// and the error flags are held until the next frame completes.
module uart_rx_fsm #(
    parameter int DATA_BITS       = 8,
    parameter int PARITY_EN       = 1,
    parameter int PARITY_ODD      = 0,
    parameter int HALF_BIT_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    input  logic                 next_bit,
    output logic                 reset_timer,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    localparam int              HW        = $clog2(HALF_BIT_CYCLES) + 1;
    localparam logic [HW-1:0]   HALF_LAST = HW'(HALF_BIT_CYCLES - 1);
    localparam logic [3:0]      BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic            PAR_EN    = (PARITY_EN != 0);
    localparam logic            PAR_ODD   = (PARITY_ODD != 0);

    logic                 sync1_q;
    logic                 rxs_q;
    state_t               state_q;
    logic [HW-1:0]        half_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 reset_timer_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_error_q;
    logic                 framing_error_q;
    logic                 busy_q;
    logic                 tick;

    // next_bit is still high during the cycle after a reset_timer pulse, because the
    // timer has not cleared it yet. It counts as a tick only while the timer is free-running.
    assign tick = next_bit & ~reset_timer_q;

    // Two-flop synchroniser. It resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            rxs_q   <= sync1_q;
        end
    end

    // Frame state machine. It also holds every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            half_q          <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            par_q           <= 1'b0;
            reset_timer_q   <= 1'b1;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    reset_timer_q <= 1'b1;
                    if (!rxs_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                        half_q  <= '0;
                    end
                end
                S_START: begin
                    if (half_q == HALF_LAST) begin
                        if (!rxs_q) begin
                            // Start bit confirmed at mid-bit. Releasing the timer now
                            // makes its ticks land on the centre of each later bit.
                            state_q       <= S_DATA;
                            reset_timer_q <= 1'b0;
                            bit_cnt_q     <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        half_q <= half_q + HW'(1);
                    end
                end
                S_DATA: begin
                    reset_timer_q <= tick;
                    if (tick) begin
                        shift_q   <= {rxs_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= PAR_EN ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    reset_timer_q <= tick;
                    if (tick) begin
                        par_q   <= rxs_q;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    reset_timer_q <= tick;
                    if (tick) begin
                        rx_data_q       <= shift_q;
                        rx_valid_q      <= 1'b1;
                        parity_error_q  <= PAR_EN & (par_q != ((^shift_q) ^ PAR_ODD));
                        framing_error_q <= ~rxs_q;
                        if (rxs_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // A line held low must return high before a new start edge counts.
                    reset_timer_q <= 1'b1;
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    busy_q        <= 1'b0;
                    reset_timer_q <= 1'b1;
                end
            endcase
        end
    end

    assign reset_timer   = reset_timer_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm. It contains a model of the companion bit timer and a
// line driver that serialises whole frames. A frame-level reference model
// derives the expected word and error flags from the bits placed on the line.
module tb_uart_rx_fsm;

    localparam int DB   = 8;
    localparam int BT   = 16;
    localparam int HALF = 8;
    localparam int PEN  = 1;
    localparam int PODD = 0;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_serial;
    logic          next_bit;
    logic          reset_timer;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          parity_error;
    logic          framing_error;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;
    int tcnt;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t expq[$];

    uart_rx_fsm #(
        .DATA_BITS      (DB),
        .PARITY_EN      (PEN),
        .PARITY_ODD     (PODD),
        .HALF_BIT_CYCLES(HALF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_serial    (rx_serial),
        .next_bit     (next_bit),
        .reset_timer  (reset_timer),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Bit timer model. It is cleared while reset_timer is high.
    // Each clear takes a one-cycle handshake, so next_bit rises at the count
    // that makes accepted ticks recur every BT clocks. Once risen, next_bit
    // stays high until the timer is cleared.
    always @(posedge clk) begin
        if (reset_timer !== 1'b0) begin
            tcnt     <= 0;
            next_bit <= 1'b0;
        end else begin
            tcnt <= tcnt + 1;
            if (tcnt == BT - 3) next_bit <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        repeat (BT) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Serialises one frame. When push is set, the task also queues what the
    // receiver should report for that frame.
    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                              input logic push);
        logic good_par;
        logic sent_par;
        exp_t e;
        good_par = (^d) ^ (PODD != 0);
        sent_par = good_par ^ flip;
        if (push) begin
            e.d  = d;
            e.pe = (PEN != 0) && (sent_par != good_par);
            e.fe = ~stop;
            expq.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PEN != 0) drive_bit(sent_par);
        drive_bit(stop);
    endtask

    // Waits for n rx_valid pulses and checks each one against the reference queue.
    task automatic collect(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            int w;
            w = 0;
            while (rx_valid !== 1'b1 && w < 400) begin
                @(negedge clk);
                w++;
            end
            if (rx_valid !== 1'b1) begin
                chk("rx_valid_timeout", 32'd0, 32'd1);
                return;
            end
            if (expq.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e.d));
                chk("parity_error", 32'(parity_error), 32'(e.pe));
                chk("framing_error", 32'(framing_error), 32'(e.fe));
            end
            @(negedge clk);
            chk("rx_valid_pulse", 32'(rx_valid), 32'd0);
        end
    endtask

    // Watches for n cycles and returns the number of rx_valid pulses seen.
    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic [7:0]  d;
        logic        flip;
        logic        stop;
        int          gap;

        reset     = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_reset_timer", 32'(reset_timer), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_parity_error", 32'(parity_error), 32'd0);
        chk("rst_framing_error", 32'(framing_error), 32'd0);
        reset = 1'b0;
        idle(10);

        // Clean frame, correct even parity
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
            collect(1);
        join
        idle(4);
        chk("a5_busy_after", 32'(busy), 32'd0);
        chk("a5_reset_timer_after", 32'(reset_timer), 32'd1);

        // Wrong parity bit
        fork
            send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
            collect(1);
        join
        idle(6);

        // Short glitch is rejected at the half-bit check
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        chk("glitch_busy_during", 32'(busy), 32'd1);
        count_valid(20, cnt);
        chk("glitch_no_valid", 32'(cnt), 32'd0);
        chk("glitch_busy_after", 32'(busy), 32'd0);
        chk("glitch_reset_timer", 32'(reset_timer), 32'd1);

        // Stop bit low, then the line is held low (break)
        fork
            send_frame(8'h81, 1'b0, 1'b0, 1'b1);
            collect(1);
        join
        rx_serial = 1'b0;
        count_valid(40, cnt);
        chk("break_busy", 32'(busy), 32'd1);
        chk("break_reset_timer", 32'(reset_timer), 32'd1);
        chk("break_no_valid", 32'(cnt), 32'd0);
        rx_serial = 1'b1;
        count_valid(200, cnt);
        chk("break_busy_released", 32'(busy), 32'd0);
        chk("break_no_second_frame", 32'(cnt), 32'd0);

        // Reset asserted in the middle of data bit 4
        d = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_serial = d[4];
        repeat (8) @(negedge clk);
        reset     = 1'b1;
        rx_serial = 1'b1;
        @(negedge clk);
        chk("midrst_reset_timer", 32'(reset_timer), 32'd1);
        chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rx_data", 32'(rx_data), 32'd0);
        chk("midrst_parity_error", 32'(parity_error), 32'd0);
        chk("midrst_framing_error", 32'(framing_error), 32'd0);
        reset = 1'b0;
        idle(30);
        fork
            send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
            collect(1);
        join
        idle(3);

        // Back-to-back frames with no idle gap
        fork
            begin
                send_frame(8'h01, 1'b0, 1'b1, 1'b1);
                send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
            end
            collect(2);
        join
        idle(5);

        // Randomised frames
        for (int f = 0; f < 16; f++) begin
            d    = 8'($urandom_range(0, 255));
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 12);
            if (!stop && gap < 2) gap = 2;
            fork
                send_frame(d, flip, stop, 1'b1);
                collect(1);
            join
            idle(gap);
        end
        idle(5);
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_queue_empty", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
